// File: rtl/gray_cntr_pipe_if.sv
// rtl/gray_cntr_pipe_if.sv - control and data bundle for gray_cntr_pipe
// GRAY_CNTR_PIPE_CHECK_EN adds the sticky err output.
interface gray_cntr_pipe_if #(
  parameter int W = 5
);
  logic         adv;
  logic         clr;
  logic [W-1:0] cntr;
  logic [W-1:0] encoded;
  logic [W-1:0] decoded;
`ifdef GRAY_CNTR_PIPE_CHECK_EN
  logic         err;

  modport master (output adv, output clr,
                  input cntr, input encoded, input decoded, input err);
  modport slave  (input adv, input clr,
                  output cntr, output encoded, output decoded, output err);
`else
  modport master (output adv, output clr,
                  input cntr, input encoded, input decoded);
  modport slave  (input adv, input clr,
                  output cntr, output encoded, output decoded);
`endif
endinterface

// File: rtl/gray_cntr_pipe.sv
// rtl/gray_cntr_pipe.sv - binary counter with registered Gray encode and decode round trip
// GRAY_CNTR_PIPE_CHECK_EN adds a sticky round-trip mismatch flag (err).
module gray_cntr_pipe #(
  parameter int           W    = 5,
  parameter int           X    = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  gray_cntr_pipe_if.slave bus
);

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Reset constants keep the pipe self-consistent from the first cycle out of reset.
  localparam logic [W-1:0] GRAY_INIT = bin2gray(INIT);
  localparam logic [W-1:0] X_W       = W'(X);

  logic [W-1:0] cntr_q, cntr_d;
  logic [W-1:0] enc_q, enc_d;
  logic [W-1:0] dec_q, dec_d;

  always_comb begin
    cntr_d = cntr_q;
    if (bus.clr) begin
      cntr_d = INIT;
    end else if (bus.adv) begin
      cntr_d = cntr_q + X_W;
    end
    enc_d = bin2gray(cntr_q);
    dec_d = gray2bin(enc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntr_q <= INIT;
      enc_q  <= GRAY_INIT;
      dec_q  <= INIT;
    end else begin
      cntr_q <= cntr_d;
      enc_q  <= enc_d;
      dec_q  <= dec_d;
    end
  end

  assign bus.cntr    = cntr_q;
  assign bus.encoded = enc_q;
  assign bus.decoded = dec_q;

`ifdef GRAY_CNTR_PIPE_CHECK_EN
  // dly2_q holds cntr from two cycles ago, aligned with decoded.
  logic [W-1:0] dly1_q, dly1_d;
  logic [W-1:0] dly2_q, dly2_d;
  logic         err_q, err_d;

  always_comb begin
    dly1_d = cntr_q;
    dly2_d = dly1_q;
    err_d  = err_q | (dec_q != dly2_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly1_q <= INIT;
      dly2_q <= INIT;
      err_q  <= 1'b0;
    end else begin
      dly1_q <= dly1_d;
      dly2_q <= dly2_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_gray_cntr_pipe.sv
// tb/tb_gray_cntr_pipe.sv - self-checking bench for gray_cntr_pipe (W=5, X=1, INIT=0)
module tb_gray_cntr_pipe;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_cntr_pipe_if #(.W(W)) bus ();

  gray_cntr_pipe #(.W(W), .X(1), .INIT(5'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: current count, the count now shown Gray-coded, the count now shown decoded.
  int m_c, m_es, m_d;

  function automatic int gray(input int n);
    return n ^ (n / 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp_v);
    checks++;
    assert (obs === 32'(exp_v))
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic r, input logic a, input logic c);
    rst     = r;
    bus.adv = a;
    bus.clr = c;
    @(posedge clk);
    if (r) begin
      m_c = 0; m_es = 0; m_d = 0;
    end else begin
      m_d  = m_es;
      m_es = m_c;
      if (c)      m_c = 0;
      else if (a) m_c = (m_c + 1) % 32;
    end
    @(negedge clk);
  endtask

  task automatic check_all();
    check("cntr", {27'd0, bus.cntr}, m_c);
    check("encoded", {27'd0, bus.encoded}, gray(m_es));
    check("decoded", {27'd0, bus.decoded}, m_d);
`ifdef GRAY_CNTR_PIPE_CHECK_EN
    check("err", {31'd0, bus.err}, 0);
`endif
  endtask

  logic [W-1:0] prev_enc;

  initial begin
    rst = 1'b1; bus.adv = 1'b1; bus.clr = 1'b1;
    m_c = 0; m_es = 0; m_d = 0;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      check_all();
      check("rst_cntr", {27'd0, bus.cntr}, 0);
      check("rst_enc", {27'd0, bus.encoded}, 0);
      check("rst_dec", {27'd0, bus.decoded}, 0);
    end

    cyc(1'b0, 1'b1, 1'b0);
    check("first_adv", {27'd0, bus.cntr}, 1);
    check_all();

    // Continuous count past the 31 -> 0 wrap.
    for (int i = 0; i < 40; i++) begin
      prev_enc = bus.encoded;
      cyc(1'b0, 1'b1, 1'b0);
      check_all();
      check("one_bit", $countones(bus.encoded ^ prev_enc), 1);
      if (m_es == 31) check("wrap_enc", {27'd0, bus.encoded}, 'h10);
      if (m_d == 31)  check("wrap_dec", {27'd0, bus.decoded}, 31);
    end

    // Hold at 7, then clear with adv also high.
    cyc(1'b0, 1'b0, 1'b1);
    check_all();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
    end
    check("at7", {27'd0, bus.cntr}, 7);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check_all();
      check("hold_cntr", {27'd0, bus.cntr}, 7);
      check("hold_enc", {27'd0, bus.encoded}, 4);
      if (i >= 1) check("hold_dec", {27'd0, bus.decoded}, 7);
    end
    cyc(1'b0, 1'b1, 1'b1);
    check("clr_cntr", {27'd0, bus.cntr}, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("clr_enc", {27'd0, bus.encoded}, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("clr_dec", {27'd0, bus.decoded}, 0);
    check_all();

    // Reset pulse mid-count at 19.
    for (int i = 0; i < 19; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("mid_cntr", {27'd0, bus.cntr}, 19);
    check("mid_enc", {27'd0, bus.encoded}, 26);
    cyc(1'b1, 1'b1, 1'b0);
    check("mrst_cntr", {27'd0, bus.cntr}, 0);
    check("mrst_enc", {27'd0, bus.encoded}, 0);
    check("mrst_dec", {27'd0, bus.decoded}, 0);

    // Random adv/clr with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0));
      check_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
